// File: rtl/mips_pkg.sv
// mips_pkg: ALU operation codes, writeback-control bit indices and bubble constants for the MIPS pipeline.
package mips_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_LUI = 4'b1011;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam int WBI_REGWRITE = 0;
    localparam int WBI_MEMTOREG = 1;
    localparam logic [3:0] NOP_ALUOP = ALU_ADD;
    localparam logic [1:0] NOP_WBI   = 2'b00;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational MIPS ALU; shifts move b by shamt, unknown codes yield zero.
module alu_core
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        aluOp,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] result
);
    always_comb begin
        case (aluOp)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = DATA_W'($signed(a) < $signed(b));
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_SRA: result = $signed(b) >>> shamt;
            ALU_LUI: result = b << 16;
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/stage_ex.sv
// stage_ex: execute stage -- operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module stage_ex
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_ex,
    input  logic [3:0]        aluOp,
    input  logic              isJump,
    input  logic              isNotConditional,
    input  logic              isEq,
    input  logic              memWrite,
    input  logic              memRead,
    input  logic [1:0]        wbi,
    input  logic              aluSrc,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] extendedInstr,
    input  logic [REG_AW-1:0] regAddr1,
    input  logic [REG_AW-1:0] regAddr2,
    input  logic [REG_AW-1:0] rs,
    input  logic              regDst,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] mem_destAddr,
    input  logic              mem_regWrite,
    input  logic              mem_isLoad,
    input  logic [DATA_W-1:0] wb_writeData,
    input  logic [REG_AW-1:0] wb_writeAddr,
    input  logic              wb_regWrite,
    output logic              isJumped,
    output logic [DATA_W-1:0] jumpAddr,
    output logic [DATA_W-1:0] aluResult_mem,
    output logic [DATA_W-1:0] storeData_mem,
    output logic [REG_AW-1:0] destAddr_mem,
    output logic              memWrite_mem,
    output logic              memRead_mem,
    output logic [1:0]        wbi_mem
);
    logic [DATA_W-1:0] opA, opB, aluB, aluResult;
    logic              memHitA, memHitB, wbHitA, wbHitB;
    // A load's MEM-stage value is an address, not data, so it never forwards from MEM.
    always_comb begin
        memHitA = mem_regWrite && !mem_isLoad && mem_destAddr == rs && rs != '0;
        memHitB = mem_regWrite && !mem_isLoad && mem_destAddr == regAddr1 && regAddr1 != '0;
        wbHitA  = wb_regWrite && wb_writeAddr == rs && rs != '0;
        wbHitB  = wb_regWrite && wb_writeAddr == regAddr1 && regAddr1 != '0;
        opA     = memHitA ? mem_result : wbHitA ? wb_writeData : reg1;
        opB     = memHitB ? mem_result : wbHitB ? wb_writeData : reg2;
        aluB    = aluSrc ? extendedInstr : opB;
    end
    alu_core #(.DATA_W(DATA_W)) u_alu (
        .aluOp (aluOp),
        .a     (opA),
        .b     (aluB),
        .shamt (extendedInstr[10:6]),
        .result(aluResult)
    );
    assign jumpAddr = pc_ex + (extendedInstr << 2);
    assign isJumped = !reset && isJump && (isNotConditional || (isEq ? opA == opB : opA != opB));
    always_ff @(posedge clock) begin
        if (reset) begin
            aluResult_mem <= '0;
            storeData_mem <= '0;
            destAddr_mem  <= '0;
            memWrite_mem  <= 1'b0;
            memRead_mem   <= 1'b0;
            wbi_mem       <= 2'b00;
        end else begin
            aluResult_mem <= aluResult;
            storeData_mem <= opB;
            destAddr_mem  <= regDst ? regAddr2 : regAddr1;
            memWrite_mem  <= memWrite;
            memRead_mem   <= memRead;
            wbi_mem       <= wbi;
        end
    end
endmodule

// File: tb/tb_stage_ex.sv
// tb_stage_ex: table-driven checks of stage_ex with a queue of expected EX/MEM register contents.
module tb_stage_ex;
    import mips_pkg::*;
    logic        clock = 1'b0, reset = 1'b1;
    logic [31:0] pc_ex, reg1, reg2, extendedInstr, mem_result, wb_writeData;
    logic [3:0]  aluOp;
    logic        isJump, isNotConditional, isEq, memWrite, memRead, aluSrc, regDst;
    logic        mem_regWrite, mem_isLoad, wb_regWrite;
    logic [1:0]  wbi;
    logic [4:0]  regAddr1, regAddr2, rs, mem_destAddr, wb_writeAddr;
    logic        isJumped, memWrite_mem, memRead_mem;
    logic [31:0] jumpAddr, aluResult_mem, storeData_mem;
    logic [4:0]  destAddr_mem;
    logic [1:0]  wbi_mem;
    int checks = 0, errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] r1, r2, imm, pc, memRes, wbData;
        logic        aluSrc, regDst, isJump, isNotCond, isEq, memRW, memLoad, wbRW, mw, mr;
        logic [4:0]  rs, rt, rd, memDest, wbAddr;
        logic [1:0]  wbi;
        logic [31:0] expRes, expStore, expJA;
        logic [4:0]  expDest;
        logic        expJ;
    } vec_t;

    typedef struct {
        logic [31:0] res, store;
        logic [4:0]  dest;
        logic [1:0]  wbi;
        logic        mw, mr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    stage_ex dut (
        .clock(clock), .reset(reset), .pc_ex(pc_ex), .aluOp(aluOp), .isJump(isJump),
        .isNotConditional(isNotConditional), .isEq(isEq), .memWrite(memWrite), .memRead(memRead),
        .wbi(wbi), .aluSrc(aluSrc), .reg1(reg1), .reg2(reg2), .extendedInstr(extendedInstr),
        .regAddr1(regAddr1), .regAddr2(regAddr2), .rs(rs), .regDst(regDst),
        .mem_result(mem_result), .mem_destAddr(mem_destAddr), .mem_regWrite(mem_regWrite),
        .mem_isLoad(mem_isLoad), .wb_writeData(wb_writeData), .wb_writeAddr(wb_writeAddr),
        .wb_regWrite(wb_regWrite), .isJumped(isJumped), .jumpAddr(jumpAddr),
        .aluResult_mem(aluResult_mem), .storeData_mem(storeData_mem), .destAddr_mem(destAddr_mem),
        .memWrite_mem(memWrite_mem), .memRead_mem(memRead_mem), .wbi_mem(wbi_mem)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(logic [3:0] op, logic [31:0] r1, r2, imm, logic src, logic [31:0] res);
        vec_t v;
        v = '{op: op, r1: r1, r2: r2, imm: imm, pc: 32'h0, memRes: 32'h0, wbData: 32'h0,
              aluSrc: src, regDst: 1'b1, isJump: 1'b0, isNotCond: 1'b0, isEq: 1'b0,
              memRW: 1'b0, memLoad: 1'b0, wbRW: 1'b0, mw: 1'b0, mr: 1'b0,
              rs: 5'd1, rt: 5'd2, rd: 5'd9, memDest: 5'd0, wbAddr: 5'd0, wbi: 2'b01,
              expRes: res, expStore: r2, expJA: 32'h0, expDest: 5'd9, expJ: 1'b0};
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        aluOp = v.op; reg1 = v.r1; reg2 = v.r2; extendedInstr = v.imm; pc_ex = v.pc;
        aluSrc = v.aluSrc; regDst = v.regDst; isJump = v.isJump; isNotConditional = v.isNotCond;
        isEq = v.isEq; memWrite = v.mw; memRead = v.mr; wbi = v.wbi;
        rs = v.rs; regAddr1 = v.rt; regAddr2 = v.rd;
        mem_result = v.memRes; mem_destAddr = v.memDest; mem_regWrite = v.memRW; mem_isLoad = v.memLoad;
        wb_writeData = v.wbData; wb_writeAddr = v.wbAddr; wb_regWrite = v.wbRW;
    endtask

    task automatic checkZero(string tag);
        check({tag, " aluResult"}, aluResult_mem, 32'h0);
        check({tag, " storeData"}, storeData_mem, 32'h0);
        check({tag, " destAddr"}, {27'h0, destAddr_mem}, 32'h0);
        check({tag, " ctrl"}, {29'h0, memWrite_mem, memRead_mem, |wbi_mem}, 32'h0);
    endtask

    initial begin
        vec_t v;
        exp_t e;
        // ALU operations
        vecs.push_back(mk(ALU_ADD, 32'd5, 32'd7, 32'h0, 1'b0, 32'd12));
        vecs.push_back(mk(ALU_SUB, 32'h0, 32'h1, 32'h0, 1'b0, 32'hFFFF_FFFF));
        vecs.push_back(mk(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h1));
        vecs.push_back(mk(ALU_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0));
        vecs.push_back(mk(ALU_SRA, 32'h0, 32'h8000_0000, 32'h100, 1'b0, 32'hF800_0000));
        vecs.push_back(mk(ALU_SRL, 32'h0, 32'h8000_0000, 32'h100, 1'b0, 32'h0800_0000));
        vecs.push_back(mk(ALU_SLL, 32'h0, 32'h1, 32'h7C0, 1'b0, 32'h8000_0000));
        vecs.push_back(mk(ALU_LUI, 32'h0, 32'h5, 32'h1234, 1'b1, 32'h1234_0000));
        vecs.push_back(mk(ALU_AND, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'hF000));
        vecs.push_back(mk(ALU_OR,  32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'hFFF0));
        vecs.push_back(mk(ALU_XOR, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'h0FF0));
        vecs.push_back(mk(ALU_NOR, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 32'hFFFF_000F));
        vecs.push_back(mk(ALU_ADD, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, 32'h1));
        vecs.push_back(mk(4'b1111, 32'h3, 32'h4, 32'h0, 1'b0, 32'h0));
        v = mk(ALU_ADD, 32'd10, 32'd3, 32'hFFFF_FFFE, 1'b1, 32'd8); v.mw = 1'b1; v.wbi = 2'b00; vecs.push_back(v);
        v = mk(ALU_ADD, 32'd10, 32'd3, 32'h4, 1'b1, 32'd14); v.mr = 1'b1; v.wbi = 2'b11; v.regDst = 1'b0; v.expDest = 5'd2; vecs.push_back(v);
        // forwarding on rs: MEM beats WB, r0 never forwards, loads skip MEM
        v = mk(ALU_ADD, 32'd1, 32'd2, 32'h0, 1'b0, 32'd102);
        v.rs = 5'd3; v.memDest = 5'd3; v.memRes = 32'd100; v.memRW = 1'b1; v.wbAddr = 5'd3; v.wbData = 32'd50; v.wbRW = 1'b1;
        vecs.push_back(v);
        v.rs = 5'd0; v.memDest = 5'd0; v.wbAddr = 5'd0; v.expRes = 32'd3; vecs.push_back(v);
        v.rs = 5'd3; v.memDest = 5'd3; v.wbAddr = 5'd3; v.memLoad = 1'b1; v.expRes = 32'd52; vecs.push_back(v);
        v.wbRW = 1'b0; v.expRes = 32'd3; vecs.push_back(v);
        // forwarding on rt into B and store data
        v = mk(ALU_ADD, 32'd1, 32'd2, 32'h0, 1'b0, 32'd201);
        v.memDest = 5'd2; v.memRes = 32'd200; v.memRW = 1'b1; v.regDst = 1'b0; v.expDest = 5'd2; v.expStore = 32'd200;
        vecs.push_back(v);
        v = mk(ALU_ADD, 32'd1, 32'd2, 32'h4, 1'b1, 32'd5);
        v.wbAddr = 5'd2; v.wbData = 32'd77; v.wbRW = 1'b1; v.expStore = 32'd77; v.mw = 1'b1; v.wbi = 2'b00;
        vecs.push_back(v);
        // branches and jumps
        v = mk(ALU_SUB, 32'd5, 32'd5, 32'hFFFF_FFFE, 1'b0, 32'h0);
        v.pc = 32'h40; v.isJump = 1'b1; v.isEq = 1'b1; v.wbi = 2'b00; v.expJ = 1'b1; v.expJA = 32'h38;
        vecs.push_back(v);
        v.r2 = 32'd6; v.expStore = 32'd6; v.expRes = 32'hFFFF_FFFF; v.expJ = 1'b0; vecs.push_back(v);
        v.isEq = 1'b0; v.expJ = 1'b1; vecs.push_back(v);
        v.isNotCond = 1'b1; v.pc = 32'h100; v.imm = 32'h4; v.expJA = 32'h110; v.r2 = 32'd5; v.expStore = 32'd5;
        v.expRes = 32'h0; vecs.push_back(v);
        v = mk(ALU_SUB, 32'd1, 32'd100, 32'hFFFF_FFFE, 1'b0, 32'h0);
        v.rs = 5'd3; v.memDest = 5'd3; v.memRes = 32'd100; v.memRW = 1'b1; v.pc = 32'h40;
        v.isJump = 1'b1; v.isEq = 1'b1; v.wbi = 2'b00; v.expJ = 1'b1; v.expJA = 32'h38;
        vecs.push_back(v);
        v = mk(ALU_SUB, 32'd5, 32'd5, 32'h0, 1'b0, 32'h0); v.isEq = 1'b1; vecs.push_back(v);
        // bubble from stage_id
        v = mk(NOP_ALUOP, 32'h0, 32'h0, 32'd32, 1'b1, 32'd32);
        v.rs = 5'd0; v.rt = 5'd0; v.rd = 5'd0; v.wbi = NOP_WBI; v.expDest = 5'd0; vecs.push_back(v);

        drive(vecs[0]);
        repeat (2) @(posedge clock);
        #1;
        check("reset isJumped", {31'h0, isJumped}, 32'h0);
        checkZero("reset");
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d isJumped", i), {31'h0, isJumped}, {31'h0, vecs[i].expJ});
            if (vecs[i].isJump) check($sformatf("v%0d jumpAddr", i), jumpAddr, vecs[i].expJA);
            sb.push_back('{res: vecs[i].expRes, store: vecs[i].expStore, dest: vecs[i].expDest,
                           wbi: vecs[i].wbi, mw: vecs[i].mw, mr: vecs[i].mr});
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL v%0d scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d aluResult", i), aluResult_mem, e.res);
                check($sformatf("v%0d storeData", i), storeData_mem, e.store);
                check($sformatf("v%0d destAddr", i), {27'h0, destAddr_mem}, {27'h0, e.dest});
                check($sformatf("v%0d ctrl", i), {28'h0, memWrite_mem, memRead_mem, wbi_mem},
                      {28'h0, e.mw, e.mr, e.wbi});
            end
        end

        // reset wins over a taken branch, after non-zero register contents
        @(negedge clock);
        drive(vecs[1]);
        @(negedge clock);
        drive(vecs[22]);
        reset = 1'b1;
        #1;
        check("reset-branch isJumped", {31'h0, isJumped}, 32'h0);
        @(posedge clock);
        #1;
        checkZero("reset-branch");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post-reset isJumped", {31'h0, isJumped}, 32'h1);
        @(posedge clock);
        #1;
        check("post-reset storeData", storeData_mem, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
